mem_ctrl: RTL and testbench

- Single-port byte-wide RAM controller and arbiter. Shares the 8-bit RAM bus between instruction fetch (IF, word reads) and the load/store buffer (LSB, 1/2/4-byte reads and writes).
- Serialises each multi-byte request into consecutive byte cycles and assembles read data little-endian.
- Handles the I/O region stall and rollback abort. Sits between the fetch unit, the LSB and the top-level RAM port.

---
 rtl/mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-wide RAM controller: arbitrates instruction-fetch words and LSB 1/2/4-byte
// accesses onto one 8-bit RAM port, serialising bytes and assembling reads little-endian.
module mem_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11,
  parameter int         IF_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        io_buffer_full,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        lsb_enable,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  input  logic [2:0]  lsb_len,
  output logic        lsb_valid,
  output logic [31:0] lsb_dout
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {GNT_IF, GNT_LSB} grant_t;

  state_t      state;
  grant_t      grant, last_grant;
  logic [2:0]  k;
  logic [2:0]  len;
  logic [31:0] addr, wdata, rdata;
  logic        ram_wr_q;

  logic [31:0] byte_addr, rdata_next;
  logic [1:0]  cap_idx;
  logic        io_stall, start_stall, pick_lsb;

  // The strobe is masked while frozen so a held write is issued exactly once, when rdy returns.
  assign ram_wr      = ram_wr_q & rdy;
  assign byte_addr   = addr + {29'd0, k};
  assign io_stall    = (byte_addr[17:16] == IO_SEL) && io_buffer_full;
  assign start_stall = (lsb_addr[17:16] == IO_SEL) && io_buffer_full;
  assign cap_idx     = 2'(k - 3'd2);

  // RAM data lags its address by one cycle, so counter value k captures byte k-2.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    rdata_next = rdata;
    if (k >= 3'd2) rdata_next[{cap_idx, 3'b000} +: 8] = ram_din;
  end

  always_comb begin
    pick_lsb = lsb_enable;
    if (if_enable && lsb_enable) pick_lsb = (last_grant == GNT_IF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= GNT_IF;
      last_grant <= GNT_IF;
      k          <= '0;
      len        <= '0;
      addr       <= '0;
      wdata      <= '0;
      rdata      <= '0;
      ram_wr_q   <= 1'b0;
      ram_a      <= '0;
      ram_dout   <= '0;
      if_valid   <= 1'b0;
      lsb_valid  <= 1'b0;
      if_data    <= '0;
      lsb_dout   <= '0;
    end else if (rdy) begin
      // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
      if_valid  <= 1'b0;
      lsb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rollback && (if_enable || lsb_enable)) begin
            rdata <= '0;
            if (pick_lsb) begin
              grant      <= GNT_LSB;
              last_grant <= GNT_LSB;
              addr       <= lsb_addr;
              len        <= lsb_len;
              wdata      <= lsb_data;
              ram_a      <= lsb_addr;
              if (lsb_wr) begin
                state <= WRITE;
                if (start_stall) begin
                  ram_wr_q <= 1'b0;
                  k        <= 3'd0;
                end else begin
                  ram_wr_q <= 1'b1;
                  ram_dout <= lsb_data[7:0];
                  k        <= 3'd1;
                end
              end else begin
                state    <= READ;
                ram_wr_q <= 1'b0;
                k        <= 3'd1;
              end
            end else begin
              grant      <= GNT_IF;
              last_grant <= GNT_IF;
              addr       <= if_addr;
              len        <= 3'(IF_LEN);
              ram_a      <= if_addr;
              ram_wr_q   <= 1'b0;
              state      <= READ;
              k          <= 3'd1;
            end
          end
        end
        READ: begin
          if (rollback) begin
            state    <= IDLE;
            ram_wr_q <= 1'b0;
          end else begin
            rdata <= rdata_next;
            k     <= k + 3'd1;
            if (k == len + 3'd1) begin
              state <= DONE;
              if (grant == GNT_IF) begin
                if_valid <= 1'b1;
                if_data  <= rdata_next;
              end else begin
                lsb_valid <= 1'b1;
                lsb_dout  <= rdata_next;
              end
            end else if (k < len) begin
              ram_a <= byte_addr;
            end
          end
        end
        WRITE: begin
          // Writes are already committed to memory-side effects, so rollback lets them finish.
          if (k == len) begin
            state     <= DONE;
            ram_wr_q  <= 1'b0;
            lsb_valid <= 1'b1;
          end else if (io_stall) begin
            ram_wr_q <= 1'b0;
          end else begin
            ram_a    <= byte_addr;
            ram_dout <= wdata[{k[1:0], 3'b000} +: 8];
            ram_wr_q <= 1'b1;
            k        <= k + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-RAM model, hand-computed expectations per cycle.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        if_enable = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_valid;
  logic [31:0] if_data;
  logic        lsb_enable = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_data = '0;
  logic [2:0]  lsb_len = 3'd1;
  logic        lsb_valid;
  logic [31:0] lsb_dout;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .io_buffer_full(io_buffer_full),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .if_enable(if_enable), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
    .lsb_enable(lsb_enable), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_data(lsb_data),
    .lsb_len(lsb_len), .lsb_valid(lsb_valid), .lsb_dout(lsb_dout)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:262143];
  int wr_count = 0, if_pulses = 0;

  always @(posedge clk) begin
    if (rst) begin
      mem[18'h00100] <= 8'h13;
      mem[18'h00101] <= 8'h05;
      mem[18'h00102] <= 8'h00;
      mem[18'h00103] <= 8'h00;
      mem[18'h02000] <= 8'h00;
      mem[18'h02001] <= 8'h00;
      mem[18'h04000] <= 8'h80;
      mem[18'h04001] <= 8'h77;
    end else if (ram_wr) begin
      mem[ram_a[17:0]] <= ram_dout;
    end
    ram_din <= mem[ram_a[17:0]];
    if (ram_wr) wr_count <= wr_count + 1;
    if (if_valid) if_pulses <= if_pulses + 1;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic wait_if_valid(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (if_valid) seen = 1'b1;
    end
  endtask

  task automatic lsb_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] n);
    lsb_enable = 1'b1;
    lsb_wr     = wr;
    lsb_addr   = a;
    lsb_data   = d;
    lsb_len    = n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic        seen;
    int          wr0, ifp0;
    logic [31:0] sw_word;

    repeat (3) @(negedge clk);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_a", ram_a, 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_valids", {30'd0, if_valid, lsb_valid}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_lsb_dout", lsb_dout, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // IF-only fetch of 13 05 00 00 at 0x100
    if_enable = 1'b1;
    if_addr   = 32'h100;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) check($sformatf("fetch_a%0d", c), ram_a, 32'h100 + 32'(c - 1));
      check($sformatf("fetch_wr%0d", c), 32'(ram_wr), 32'd0);
      check($sformatf("fetch_vld%0d", c), 32'(if_valid), 32'(c == 6));
    end
    check("fetch_data", if_data, 32'h0000_0513);
    if_enable = 1'b0;
    @(negedge clk);

    // SH 0xDEADBEEF at 0x2002 (leaves last_grant = LSB)
    lsb_req(1'b1, 32'h2002, 32'hDEAD_BEEF, 3'd2);
    @(negedge clk);
    check("sh_c1", {ram_wr, 15'd0, ram_a[15:0]}, {1'b1, 15'd0, 16'h2002});
    check("sh_c1_d", 32'(ram_dout), 32'hEF);
    @(negedge clk);
    check("sh_c2", {ram_wr, 15'd0, ram_a[15:0]}, {1'b1, 15'd0, 16'h2003});
    check("sh_c2_d", 32'(ram_dout), 32'hBE);
    @(negedge clk);
    check("sh_c3_vld", {30'd0, ram_wr, lsb_valid}, 32'd1);
    lsb_enable = 1'b0;
    @(negedge clk);
    check("sh_mem", {16'd0, mem[32'h2003], mem[32'h2002]}, 32'h0000_BEEF);

    // Both request with last_grant = LSB: IF first, then LSB, then IF again
    if_enable = 1'b1;
    if_addr   = 32'h100;
    lsb_req(1'b0, 32'h2003, 32'h0, 3'd1);
    @(negedge clk);
    check("arb_if_first", ram_a, 32'h100);
    repeat (5) @(negedge clk);
    check("arb_if_vld", {30'd0, if_valid, lsb_valid}, 32'd2);
    if_addr = 32'h2000;
    @(negedge clk);
    @(negedge clk);
    check("arb_lsb_rr", ram_a, 32'h2003);
    @(negedge clk);
    @(negedge clk);
    check("arb_lsb_vld", {30'd0, if_valid, lsb_valid}, 32'd1);
    check("arb_lsb_dout", lsb_dout, 32'h0000_00BE);
    lsb_enable = 1'b0;
    wait_if_valid(12, seen);
    check("arb_if2_seen", 32'(seen), 32'd1);
    check("arb_if2_data", if_data, 32'hBEEF_0000);
    if_enable = 1'b0;
    @(negedge clk);

    // SB to I/O space with the output FIFO full for three edges
    wr0 = wr_count;
    io_buffer_full = 1'b1;
    lsb_req(1'b1, 32'h0003_0000, 32'h0000_005A, 3'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("io_stall%0d", c), 32'(ram_wr), 32'd0);
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_wr", {ram_wr, 7'd0, ram_dout, ram_a[15:0]}, {1'b1, 7'd0, 8'h5A, 16'h0000});
    check("io_addr", ram_a, 32'h0003_0000);
    @(negedge clk);
    check("io_vld", {30'd0, ram_wr, lsb_valid}, 32'd1);
    lsb_enable = 1'b0;
    @(negedge clk);
    check("io_once", 32'(wr_count - wr0), 32'd1);

    // Rollback mid-fetch, then a SW that rolls back at byte 1 but completes
    ifp0 = if_pulses;
    if_enable = 1'b1;
    if_addr   = 32'h100;
    @(negedge clk);
    @(negedge clk);
    check("rb_fetch_a2", ram_a, 32'h101);
    rollback  = 1'b1;
    if_enable = 1'b0;
    @(negedge clk);
    rollback = 1'b0;
    sw_word  = 32'h1122_3344;
    lsb_req(1'b1, 32'h3000, sw_word, 3'd4);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("rb_sw_a%0d", c), {ram_wr, 31'(ram_a)}, {1'b1, 31'(32'h3000 + 32'(c - 1))});
      check($sformatf("rb_sw_d%0d", c), 32'(ram_dout), (sw_word >> (8 * (c - 1))) & 32'hFF);
      rollback = (c == 1);
    end
    @(negedge clk);
    check("rb_sw_vld", 32'(lsb_valid), 32'd1);
    lsb_enable = 1'b0;
    @(negedge clk);
    check("rb_sw_mem", mem_word(32'h3000), sw_word);
    check("rb_no_if_vld", 32'(if_pulses - ifp0), 32'd0);

    // LB of 0x80 with rdy low for two edges mid-read
    wr0 = wr_count;
    lsb_req(1'b0, 32'h4000, 32'h0, 3'd1);
    @(negedge clk);
    check("lb_a", ram_a, 32'h4000);
    rdy = 1'b0;
    @(negedge clk);
    check("lb_frz1", 32'(lsb_valid), 32'd0);
    @(negedge clk);
    rdy = 1'b1;
    check("lb_frz2", 32'(lsb_valid), 32'd0);
    @(negedge clk);
    check("lb_c4", 32'(lsb_valid), 32'd0);
    @(negedge clk);
    check("lb_vld", 32'(lsb_valid), 32'd1);
    check("lb_dout", lsb_dout, 32'h0000_0080);
    lsb_enable = 1'b0;
    @(negedge clk);
    check("lb_no_wr", 32'(wr_count - wr0), 32'd0);

    // SH with rdy low for one edge: write strobe masked, byte re-driven once
    wr0 = wr_count;
    lsb_req(1'b1, 32'h5000, 32'h0000_CAFE, 3'd2);
    @(negedge clk);
    check("frz_sh_c1", {ram_wr, 7'd0, ram_dout, ram_a[15:0]}, {1'b1, 7'd0, 8'hFE, 16'h5000});
    rdy = 1'b0;
    @(negedge clk);
    check("frz_sh_wr0", {ram_wr, 15'd0, ram_a[15:0]}, {1'b0, 15'd0, 16'h5000});
    rdy = 1'b1;
    @(negedge clk);
    check("frz_sh_c3", {ram_wr, 7'd0, ram_dout, ram_a[15:0]}, {1'b1, 7'd0, 8'hCA, 16'h5001});
    @(negedge clk);
    check("frz_sh_vld", 32'(lsb_valid), 32'd1);
    lsb_enable = 1'b0;
    @(negedge clk);
    check("frz_sh_count", 32'(wr_count - wr0), 32'd2);
    check("frz_sh_mem", {16'd0, mem[32'h5001], mem[32'h5000]}, 32'h0000_CAFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
